// File: rtl/mc_loader.sv
// -----------------------------------------------------------------------------
// mc_loader
//
// Boot-time loader for the 64-bit microcode control store. A byte stream
// arrives over a valid/ready handshake; every eight bytes are packed into one
// microword (first byte in the most significant lane). Each finished word is
// written into the control store with a SETUP / STROBE / HOLD sequence on the
// active-low strobes. Words are written in order at addresses 0..WORDS-1,
// after which the loader reports completion so the sequencer can start
// fetching.
//
// Parameters
//   WORDS     number of microwords to load (1..256)
//   WR_PULSE  number of cycles _w is held low per write (>= 1)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   start       one-cycle pulse, begins a load when idle or done
//   byte_in     stream byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  loader accepts a byte this cycle (COLLECT only)
//   _cs         control-store chip select, active low
//   _oe         control-store output enable, active low (held inactive)
//   _w          control-store write strobe, active low
//   addr        control-store word address
//   data_in     word being written, drives the store's data input
//   busy        load in progress
//   done        all WORDS written
//   checksum    mod-256 sum of all bytes accepted since start
//
// Every output comes straight from a register, so the store sees clean,
// glitch-free strobes. addr and data_in only change in COLLECT (and on a
// new start), never while _cs is low, which gives at least one cycle of
// setup before _w falls and one cycle of hold after _w rises.
// -----------------------------------------------------------------------------
module mc_loader #(
    parameter int WORDS    = 256,
    parameter int WR_PULSE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        _cs,
    output logic        _oe,
    output logic        _w,
    output logic [7:0]  addr,
    output logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    // Width of the strobe-length counter; it only has to count 0..WR_PULSE-1.
    localparam int              PCW        = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [PCW-1:0]  PULSE_LAST = PCW'(WR_PULSE - 1);
    localparam logic [7:0]      LAST_ADDR  = 8'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [2:0]      byte_cnt_reg;
    logic [PCW-1:0]  pulse_cnt_reg;
    logic [7:0]      addr_reg;
    logic [7:0]      checksum_reg;
    logic [63:0]     data_reg;
    logic            byte_ready_reg;
    logic            cs_n_reg;
    logic            w_n_reg;
    logic            busy_reg;
    logic            done_reg;

    // A byte transfers when the loader is ready and the source is valid.
    // byte_ready_reg is high exactly while the FSM sits in COLLECT.
    logic            byte_take;
    logic [63:0]     data_next;
    logic [7:0]      checksum_next;

    assign byte_take     = byte_ready_reg & byte_valid;
    assign checksum_next = checksum_reg + byte_in;

    // Byte-lane steering. Lane gi covers data bits [8*gi+7 : 8*gi]; the first
    // byte of a word (count 0) belongs in lane 7, the eighth (count 7) in
    // lane 0. Lanes not addressed this cycle keep their contents, so a word
    // interrupted by a stall is retained as-is.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [2:0] LANE_SLOT = 3'(7 - gi);

            assign data_next[8*gi +: 8] =
                (byte_take && (byte_cnt_reg == LANE_SLOT)) ? byte_in
                                                           : data_reg[8*gi +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Load sequencer. Outputs are set on the transition into the state that
    // needs them, so each one is a plain register with no decode behind it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            byte_cnt_reg   <= 3'd0;
            pulse_cnt_reg  <= '0;
            addr_reg       <= 8'd0;
            checksum_reg   <= 8'd0;
            data_reg       <= 64'd0;
            byte_ready_reg <= 1'b0;
            cs_n_reg       <= 1'b1;
            w_n_reg        <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                // A new load can begin from reset-idle or after a finished
                // load; any other state ignores start.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg      <= ST_COLLECT;
                        addr_reg       <= 8'd0;
                        byte_cnt_reg   <= 3'd0;
                        checksum_reg   <= 8'd0;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        byte_ready_reg <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    if (byte_take) begin
                        data_reg     <= data_next;
                        checksum_reg <= checksum_next;
                        byte_cnt_reg <= byte_cnt_reg + 3'd1;
                        // The eighth byte completes the word: stop accepting
                        // and select the store for one cycle of setup.
                        if (byte_cnt_reg == 3'd7) begin
                            state_reg      <= ST_SETUP;
                            byte_ready_reg <= 1'b0;
                            cs_n_reg       <= 1'b0;
                        end
                    end
                end

                ST_SETUP: begin
                    state_reg     <= ST_STROBE;
                    w_n_reg       <= 1'b0;
                    pulse_cnt_reg <= '0;
                end

                ST_STROBE: begin
                    if (pulse_cnt_reg == PULSE_LAST) begin
                        state_reg <= ST_HOLD;
                        w_n_reg   <= 1'b1;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
                    end
                end

                // addr/data_in stay put through this cycle so the store has
                // hold time after _w rises; the address advances only on the
                // way back into COLLECT, never past the last word.
                ST_HOLD: begin
                    cs_n_reg <= 1'b1;
                    if (addr_reg == LAST_ADDR) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg      <= ST_COLLECT;
                        addr_reg       <= addr_reg + 8'd1;
                        byte_cnt_reg   <= 3'd0;
                        byte_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    byte_ready_reg <= 1'b0;
                    cs_n_reg       <= 1'b1;
                    w_n_reg        <= 1'b1;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign _cs        = cs_n_reg;
    assign _w         = w_n_reg;
    assign _oe        = 1'b1;       // the loader only ever writes the store
    assign addr       = addr_reg;
    assign data_in    = data_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign checksum   = checksum_reg;

endmodule
